// File: rtl/cjtag_crc_parity_tx.sv
// cJTAG transmit framer: forwards payload bytes and appends
// CRC-8 and parity trailer bytes at the end of each frame.
module cjtag_crc_parity_tx #(
  parameter bit         ENABLE_CRC     = 1'b1,
  parameter bit         ENABLE_PARITY  = 1'b1,
  parameter logic [7:0] CRC_POLYNOMIAL = 8'h07,
  parameter logic [7:0] CRC_INIT       = 8'hFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  input  logic        s_last,
  output logic        s_ready,
  output logic [7:0]  m_data,
  output logic        m_valid,
  output logic        m_last,
  output logic [1:0]  m_kind,
  input  logic        m_ready,
  output logic [7:0]  crc_value,
  output logic        parity_bit,
  input  logic        abort,
  input  logic        clear_stats,
  output logic [15:0] frame_count,
  output logic [15:0] abort_count
);

  localparam logic [1:0] ST_PAY = 2'd0;
  localparam logic [1:0] ST_CRC = 2'd1;
  localparam logic [1:0] ST_PAR = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [7:0]  crc_q, crc_d;
  logic        par_q, par_d;
  logic        in_frame_q, in_frame_d;
  logic [7:0]  m_data_q, m_data_d;
  logic        m_valid_q, m_valid_d;
  logic        m_last_q, m_last_d;
  logic [1:0]  m_kind_q, m_kind_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic [15:0] abort_cnt_q, abort_cnt_d;
  logic        free;
  logic        drain;

  function automatic logic [7:0] crc_step(
    input logic [7:0] c,
    input logic [7:0] d
  );
    logic [7:0] x;
    x = c ^ d;
    for (int i = 0; i < 8; i++) begin
      x = x[7] ? ((x << 1) ^ CRC_POLYNOMIAL) : (x << 1);
    end
    return x;
  endfunction

  assign free    = !m_valid_q || m_ready;
  assign drain   = m_valid_q && m_ready;
  assign s_ready = !rst && (state_q == ST_PAY) && free && !abort;

  always_comb begin
    state_d     = state_q;
    crc_d       = crc_q;
    par_d       = par_q;
    in_frame_d  = in_frame_q;
    m_data_d    = m_data_q;
    m_valid_d   = m_valid_q;
    m_last_d    = m_last_q;
    m_kind_d    = m_kind_q;
    frame_cnt_d = frame_cnt_q;
    abort_cnt_d = abort_cnt_q;

    if (drain && m_last_q) frame_cnt_d = frame_cnt_q + 16'd1;
    if (abort && (in_frame_q || state_q != ST_PAY))
      abort_cnt_d = abort_cnt_q + 16'd1;
    if (clear_stats) begin
      frame_cnt_d = '0;
      abort_cnt_d = '0;
    end

    if (abort) begin
      state_d    = ST_PAY;
      crc_d      = CRC_INIT;
      par_d      = 1'b0;
      in_frame_d = 1'b0;
      m_valid_d  = 1'b0;
    end else begin
      if (drain) m_valid_d = 1'b0;
      case (state_q)
        ST_PAY: begin
          if (s_valid && s_ready) begin
            m_valid_d  = 1'b1;
            m_data_d   = s_data;
            m_kind_d   = 2'd0;
            m_last_d   = 1'b0;
            in_frame_d = 1'b1;
            if (ENABLE_CRC) crc_d = crc_step(crc_q, s_data);
            if (ENABLE_PARITY) par_d = par_q ^ (^s_data);
            if (s_last) begin
              if (ENABLE_CRC) state_d = ST_CRC;
              else if (ENABLE_PARITY) state_d = ST_PAR;
              else begin
                m_last_d   = 1'b1;
                in_frame_d = 1'b0;
              end
            end
          end
        end
        ST_CRC: begin
          if (free) begin
            m_valid_d = 1'b1;
            m_data_d  = crc_q;
            m_kind_d  = 2'd1;
            m_last_d  = !ENABLE_PARITY;
            if (ENABLE_PARITY) state_d = ST_PAR;
            else begin
              state_d    = ST_PAY;
              crc_d      = CRC_INIT;
              par_d      = 1'b0;
              in_frame_d = 1'b0;
            end
          end
        end
        ST_PAR: begin
          if (free) begin
            m_valid_d  = 1'b1;
            m_data_d   = {7'b0, par_q};
            m_kind_d   = 2'd2;
            m_last_d   = 1'b1;
            state_d    = ST_PAY;
            crc_d      = CRC_INIT;
            par_d      = 1'b0;
            in_frame_d = 1'b0;
          end
        end
        default: state_d = ST_PAY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_PAY;
      crc_q       <= CRC_INIT;
      par_q       <= 1'b0;
      in_frame_q  <= 1'b0;
      m_data_q    <= '0;
      m_valid_q   <= 1'b0;
      m_last_q    <= 1'b0;
      m_kind_q    <= '0;
      frame_cnt_q <= '0;
      abort_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      crc_q       <= crc_d;
      par_q       <= par_d;
      in_frame_q  <= in_frame_d;
      m_data_q    <= m_data_d;
      m_valid_q   <= m_valid_d;
      m_last_q    <= m_last_d;
      m_kind_q    <= m_kind_d;
      frame_cnt_q <= frame_cnt_d;
      abort_cnt_q <= abort_cnt_d;
    end
  end

  assign m_data      = m_data_q;
  assign m_valid     = m_valid_q;
  assign m_last      = m_last_q;
  assign m_kind      = m_kind_q;
  assign crc_value   = crc_q;
  assign parity_bit  = par_q;
  assign frame_count = frame_cnt_q;
  assign abort_count = abort_cnt_q;

endmodule

// File: tb/tb_cjtag_crc_parity_tx.sv
// Directed bench for cjtag_crc_parity_tx in three
// parameter configurations sharing one stimulus bus.
module tb_cjtag_crc_parity_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] s_data = '0;
  logic       s_valid = 1'b0;
  logic       s_last = 1'b0;
  logic       m_ready = 1'b0;
  logic       abort = 1'b0;
  logic       clear_stats = 1'b0;

  logic        rdy_m, mv_m, ml_m, par_m;
  logic [7:0]  md_m, crc_m;
  logic [1:0]  mk_m;
  logic [15:0] fc_m, ac_m;

  logic        rdy_n, mv_n, ml_n, par_n;
  logic [7:0]  md_n, crc_n;
  logic [1:0]  mk_n;
  logic [15:0] fc_n, ac_n;

  logic        rdy_c, mv_c, ml_c, par_c;
  logic [7:0]  md_c, crc_c;
  logic [1:0]  mk_c;
  logic [15:0] fc_c, ac_c;

  int n_cmp = 0;
  int n_err = 0;
  bit mon_en = 1'b1;

  logic [10:0] mq[$];
  logic [10:0] nq[$];
  logic [10:0] cq[$];

  always #5 clk = ~clk;

  cjtag_crc_parity_tx #(.ENABLE_CRC(1'b1), .ENABLE_PARITY(1'b1)) dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid),
    .s_last(s_last), .s_ready(rdy_m), .m_data(md_m), .m_valid(mv_m),
    .m_last(ml_m), .m_kind(mk_m), .m_ready(m_ready),
    .crc_value(crc_m), .parity_bit(par_m), .abort(abort),
    .clear_stats(clear_stats), .frame_count(fc_m), .abort_count(ac_m)
  );

  cjtag_crc_parity_tx #(.ENABLE_CRC(1'b0), .ENABLE_PARITY(1'b0)) dut_nn (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid),
    .s_last(s_last), .s_ready(rdy_n), .m_data(md_n), .m_valid(mv_n),
    .m_last(ml_n), .m_kind(mk_n), .m_ready(m_ready),
    .crc_value(crc_n), .parity_bit(par_n), .abort(abort),
    .clear_stats(clear_stats), .frame_count(fc_n), .abort_count(ac_n)
  );

  cjtag_crc_parity_tx #(.ENABLE_CRC(1'b1), .ENABLE_PARITY(1'b0)) dut_c (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid),
    .s_last(s_last), .s_ready(rdy_c), .m_data(md_c), .m_valid(mv_c),
    .m_last(ml_c), .m_kind(mk_c), .m_ready(m_ready),
    .crc_value(crc_c), .parity_bit(par_c), .abort(abort),
    .clear_stats(clear_stats), .frame_count(fc_c), .abort_count(ac_c)
  );

  // Record every output handshake as {last, kind, data}.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (mv_m && m_ready) mq.push_back({ml_m, mk_m, md_m});
      if (mv_n && m_ready) nq.push_back({ml_n, mk_n, md_n});
      if (mv_c && m_ready) cq.push_back({ml_c, mk_c, md_c});
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
  endtask

  task automatic send(input logic [7:0] d, input logic l, input int sel);
    bit got;
    logic r;
    got = 1'b0;
    s_data = d;
    s_last = l;
    s_valid = 1'b1;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      r = (sel == 0) ? rdy_m : (sel == 1) ? rdy_n : rdy_c;
      if (r) got = 1'b1;
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last = 1'b0;
    if (!got) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout: byte %h never accepted", d);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (mv_m !== 1'b0) begin n_err++; $display("FAIL rst_m_valid: got %b want 0", mv_m); end
    n_cmp++; if (md_m !== 8'h00) begin n_err++; $display("FAIL rst_m_data: got %h want 00", md_m); end
    n_cmp++; if (ml_m !== 1'b0) begin n_err++; $display("FAIL rst_m_last: got %b want 0", ml_m); end
    n_cmp++; if (mk_m !== 2'd0) begin n_err++; $display("FAIL rst_m_kind: got %0d want 0", mk_m); end
    n_cmp++; if (crc_m !== 8'hFF) begin n_err++; $display("FAIL rst_crc: got %h want ff", crc_m); end
    n_cmp++; if (par_m !== 1'b0) begin n_err++; $display("FAIL rst_parity: got %b want 0", par_m); end
    n_cmp++; if (fc_m !== 16'd0) begin n_err++; $display("FAIL rst_frame_count: got %0d want 0", fc_m); end
    n_cmp++; if (ac_m !== 16'd0) begin n_err++; $display("FAIL rst_abort_count: got %0d want 0", ac_m); end
    s_valid = 1'b1;
    m_ready = 1'b1;
    #1;
    n_cmp++; if (rdy_m !== 1'b0) begin n_err++; $display("FAIL rst_s_ready: got %b want 0", rdy_m); end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_single_zero();
    logic [10:0] e[$];
    e = '{{1'b0, 2'd0, 8'h00}, {1'b0, 2'd1, 8'hF3}, {1'b1, 2'd2, 8'h00}};
    m_ready = 1'b1;
    mq.delete();
    send(8'h00, 1'b1, 0);
    idle(8);
    n_cmp++; if (mq.size() != 3) begin n_err++; $display("FAIL zero_count: got %0d bytes want 3", mq.size()); end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (mq[i] !== e[i]) begin n_err++; $display("FAIL zero_byte%0d: got %h want %h", i, mq[i], e[i]); end
    end
    n_cmp++; if (fc_m !== 16'd1) begin n_err++; $display("FAIL zero_frame_count: got %0d want 1", fc_m); end
  endtask

  task automatic test_single_one();
    logic [10:0] e[$];
    e = '{{1'b0, 2'd0, 8'h01}, {1'b0, 2'd1, 8'hF4}, {1'b1, 2'd2, 8'h01},
          {1'b0, 2'd0, 8'h01}, {1'b0, 2'd1, 8'hF4}, {1'b1, 2'd2, 8'h01}};
    mq.delete();
    send(8'h01, 1'b1, 0);
    idle(6);
    send(8'h01, 1'b1, 0);
    idle(8);
    n_cmp++; if (mq.size() != 6) begin n_err++; $display("FAIL one_count: got %0d bytes want 6", mq.size()); end
    for (int i = 0; i < 6; i++) begin
      n_cmp++;
      if (mq[i] !== e[i]) begin n_err++; $display("FAIL one_byte%0d: got %h want %h", i, mq[i], e[i]); end
    end
    n_cmp++; if (fc_m !== 16'd3) begin n_err++; $display("FAIL one_frame_count: got %0d want 3", fc_m); end
  endtask

  task automatic test_stall();
    logic [10:0] e[$];
    e = '{{1'b0, 2'd0, 8'h12}, {1'b0, 2'd0, 8'h34}, {1'b0, 2'd0, 8'h56},
          {1'b0, 2'd0, 8'h78}, {1'b0, 2'd1, 8'hCD}, {1'b1, 2'd2, 8'h01}};
    mq.delete();
    m_ready = 1'b1;
    send(8'h12, 1'b0, 0);
    send(8'h34, 1'b0, 0);
    m_ready = 1'b0;
    s_data = 8'h56;
    s_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++; if (rdy_m !== 1'b0) begin n_err++; $display("FAIL stall_s_ready%0d: got %b want 0", i, rdy_m); end
      n_cmp++; if (md_m !== 8'h34) begin n_err++; $display("FAIL stall_m_data%0d: got %h want 34", i, md_m); end
      n_cmp++; if (mv_m !== 1'b1) begin n_err++; $display("FAIL stall_m_valid%0d: got %b want 1", i, mv_m); end
    end
    @(posedge clk);
    #1;
    m_ready = 1'b1;
    send(8'h56, 1'b0, 0);
    send(8'h78, 1'b1, 0);
    idle(8);
    n_cmp++; if (mq.size() != 6) begin n_err++; $display("FAIL stall_count: got %0d bytes want 6", mq.size()); end
    for (int i = 0; i < 6; i++) begin
      n_cmp++;
      if (mq[i] !== e[i]) begin n_err++; $display("FAIL stall_byte%0d: got %h want %h", i, mq[i], e[i]); end
    end
    n_cmp++; if (fc_m !== 16'd4) begin n_err++; $display("FAIL stall_frame_count: got %0d want 4", fc_m); end
  endtask

  task automatic test_abort();
    logic [10:0] e[$];
    e = '{{1'b0, 2'd0, 8'h00}, {1'b0, 2'd1, 8'hF3}, {1'b1, 2'd2, 8'h00}};
    m_ready = 1'b1;
    send(8'hAA, 1'b0, 0);
    send(8'hBB, 1'b0, 0);
    m_ready = 1'b0;
    abort = 1'b1;
    s_valid = 1'b1;
    @(negedge clk);
    n_cmp++; if (rdy_m !== 1'b0) begin n_err++; $display("FAIL abort_s_ready: got %b want 0", rdy_m); end
    @(posedge clk);
    #1;
    abort = 1'b0;
    s_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (mv_m !== 1'b0) begin n_err++; $display("FAIL abort_m_valid: got %b want 0", mv_m); end
    n_cmp++; if (ac_m !== 16'd1) begin n_err++; $display("FAIL abort_count: got %0d want 1", ac_m); end
    n_cmp++; if (fc_m !== 16'd4) begin n_err++; $display("FAIL abort_frame_count: got %0d want 4", fc_m); end
    n_cmp++; if (crc_m !== 8'hFF) begin n_err++; $display("FAIL abort_crc: got %h want ff", crc_m); end
    n_cmp++; if (par_m !== 1'b0) begin n_err++; $display("FAIL abort_parity: got %b want 0", par_m); end
    @(posedge clk);
    #1;
    m_ready = 1'b1;
    mq.delete();
    send(8'h00, 1'b1, 0);
    idle(8);
    n_cmp++; if (mq.size() != 3) begin n_err++; $display("FAIL post_abort_count: got %0d bytes want 3", mq.size()); end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (mq[i] !== e[i]) begin n_err++; $display("FAIL post_abort_byte%0d: got %h want %h", i, mq[i], e[i]); end
    end
    n_cmp++; if (fc_m !== 16'd5) begin n_err++; $display("FAIL post_abort_frames: got %0d want 5", fc_m); end
    n_cmp++; if (ac_m !== 16'd1) begin n_err++; $display("FAIL post_abort_aborts: got %0d want 1", ac_m); end
  endtask

  task automatic test_variants();
    do_reset();
    mq.delete();
    nq.delete();
    cq.delete();
    m_ready = 1'b1;
    send(8'hA5, 1'b0, 1);
    send(8'h5A, 1'b1, 1);
    idle(8);
    n_cmp++; if (nq.size() != 2) begin n_err++; $display("FAIL nn_count: got %0d bytes want 2", nq.size()); end
    n_cmp++; if (nq[0] !== {1'b0, 2'd0, 8'hA5}) begin n_err++; $display("FAIL nn_byte0: got %h want 0a5", nq[0]); end
    n_cmp++; if (nq[1] !== {1'b1, 2'd0, 8'h5A}) begin n_err++; $display("FAIL nn_byte1: got %h want 45a", nq[1]); end
    n_cmp++; if (fc_n !== 16'd1) begin n_err++; $display("FAIL nn_frame_count: got %0d want 1", fc_n); end
    n_cmp++; if (cq[2] !== {1'b1, 2'd1, 8'h0F}) begin n_err++; $display("FAIL c_trailer_a5: got %h want 50f", cq[2]); end
    cq.delete();
    send(8'h01, 1'b1, 2);
    idle(8);
    n_cmp++; if (cq.size() != 2) begin n_err++; $display("FAIL c_count: got %0d bytes want 2", cq.size()); end
    n_cmp++; if (cq[0] !== {1'b0, 2'd0, 8'h01}) begin n_err++; $display("FAIL c_byte0: got %h want 001", cq[0]); end
    n_cmp++; if (cq[1] !== {1'b1, 2'd1, 8'hF4}) begin n_err++; $display("FAIL c_byte1: got %h want 4f4", cq[1]); end
    n_cmp++; if (fc_c !== 16'd2) begin n_err++; $display("FAIL c_frame_count: got %0d want 2", fc_c); end
  endtask

  task automatic test_clear_stats();
    bit hit;
    do_reset();
    m_ready = 1'b0;
    send(8'h00, 1'b1, 0);
    m_ready = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      @(negedge clk);
      if (mv_m && ml_m && m_ready) hit = 1'b1;
    end
    clear_stats = hit;
    @(posedge clk);
    #1;
    clear_stats = 1'b0;
    n_cmp++; if (!hit) begin n_err++; $display("FAIL clear_no_last: got none want m_last handshake"); end
    n_cmp++; if (fc_m !== 16'd0) begin n_err++; $display("FAIL clear_wins: got %0d want 0", fc_m); end
    send(8'h01, 1'b1, 0);
    idle(8);
    n_cmp++; if (fc_m !== 16'd1) begin n_err++; $display("FAIL clear_after: got %0d want 1", fc_m); end
  endtask

  task automatic test_wrap();
    int acc;
    do_reset();
    mon_en = 1'b0;
    m_ready = 1'b1;
    s_data = 8'h3C;
    s_last = 1'b1;
    s_valid = 1'b1;
    acc = 0;
    for (int i = 0; i < 70000 && acc < 65536; i++) begin
      @(negedge clk);
      if (rdy_n) acc++;
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last = 1'b0;
    idle(4);
    mon_en = 1'b1;
    n_cmp++; if (acc != 65536) begin n_err++; $display("FAIL wrap_accepts: got %0d want 65536", acc); end
    n_cmp++; if (fc_n !== 16'd0) begin n_err++; $display("FAIL wrap_frame_count: got %h want 0000", fc_n); end
    n_cmp++; if (ac_n !== 16'd0) begin n_err++; $display("FAIL wrap_abort_count: got %0d want 0", ac_n); end
  endtask

  initial begin
    test_reset();
    test_single_zero();
    test_single_one();
    test_stall();
    test_abort();
    test_variants();
    test_clear_stats();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
